// File: rtl/mul_div_pkg.sv
// Shared opcode encodings, FSM states and decode helpers for the multiply/divide unit.
package mul_div_pkg;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   function automatic logic is_div(logic [2:0] funct3);
      return funct3[2];
   endfunction

   function automatic logic op1_signed(logic [2:0] funct3);
      return funct3 inside {MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op2_signed(logic [2:0] funct3);
      return funct3 inside {MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
interface mul_div_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            start;
   logic            abort;
   logic [2:0]      funct3;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, abort, funct3, data1, data2,
      input  busy, done, result
   );

   modport slave (
      input  start, abort, funct3, data1, data2,
      output busy, done, result
   );
endinterface

// File: rtl/mul_div_datapath.sv
// Operand magnitudes, shift-add / restoring shift-subtract step and result sign fix-up.
module mul_div_datapath
   import mul_div_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic            step,
   input  logic [2:0]      funct3,  // raw opcode, used on load
   input  logic [2:0]      op,      // captured opcode, used while iterating
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   output logic [XLEN-1:0] result
);

   // hi_q:lo_q is the product accumulator, or remainder:quotient when dividing
   logic [XLEN-1:0] hi_q, lo_q, opb_q;
   logic            neg_q_q, neg_r_q, dvz_q;

   logic            sign1, sign2;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN:0]   sum, shifted, diff;
   logic            ge;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quot, rem;

   // Operand magnitudes and one iteration of either algorithm
   always_comb begin
      sign1   = op1_signed(funct3) & data1[XLEN-1];
      sign2   = op2_signed(funct3) & data2[XLEN-1];
      mag1    = sign1 ? -data1 : data1;
      mag2    = sign2 ? -data2 : data2;
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      shifted = {hi_q, lo_q[XLEN-1]};
      diff    = shifted - {1'b0, opb_q};
      ge      = shifted >= {1'b0, opb_q};
   end

   // Accumulator and sign flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q    <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dvz_q   <= 1'b0;
      end else if (load) begin
         hi_q    <= '0;
         lo_q    <= mag1;
         opb_q   <= mag2;
         neg_q_q <= sign1 ^ sign2;
         neg_r_q <= sign1;
         dvz_q   <= (data2 == '0);
      end else if (step) begin
         if (is_div(op)) begin
            hi_q <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], ge};
         end else begin
            hi_q <= sum[XLEN:1];
            lo_q <= {sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   // Sign fix-up and result selection
   always_comb begin
      prod   = {hi_q, lo_q};
      if (neg_q_q) prod = -prod;
      // Divide by zero keeps the all-ones quotient regardless of dividend sign
      quot   = (neg_q_q && !dvz_q) ? -lo_q : lo_q;
      rem    = neg_r_q ? -hi_q : hi_q;
      result = '0;
      unique case (op)
         MUL:                 result = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: result = prod[2*XLEN-1:XLEN];
         DIV, DIVU:           result = quot;
         REM, REMU:           result = rem;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter and handshake.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   mul_div_unit_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   result_q, result_d, dp_result;
   logic              done_q, done_d;
   logic              load, step;

   mul_div_datapath #(.XLEN(XLEN)) u_datapath (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .step    (step),
      .funct3  (bus.funct3),
      .op      (funct3_q),
      .data1   (bus.data1),
      .data2   (bus.data2),
      .result  (dp_result)
   );

   // Next state, counter and completion
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load     = 1'b0;
      step     = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
            if (!bus.abort) begin
               done_d   = 1'b1;
               result_d = dp_result;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, captured opcode and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         funct3_q <= MUL;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
         if (load) funct3_q <= bus.funct3;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
